// File: rtl/axis_row_generator.sv
// AXI-Stream row source: emits row_count rows of BEATS_PER_ROW beats with an optional idle gap
// between rows. Lane k of beat b in row r carries {r[15:0], b[7:0], k[7:0]}.
module axis_row_generator #(
  parameter int DATA_WIDTH    = 512,
  parameter int BEATS_PER_ROW = 66
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [31:0]           row_count,
  input  logic [15:0]           gap_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rows_sent,
  output logic [DATA_WIDTH-1:0] AXIS_TDATA,
  output logic                  AXIS_TVALID,
  output logic                  AXIS_TLAST,
  input  logic                  AXIS_TREADY
);

  localparam int         LANES     = DATA_WIDTH / 32;
  localparam logic [7:0] LAST_BEAT = 8'(BEATS_PER_ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rows_total_q, rows_total_d;
  logic [31:0] rows_sent_q, rows_sent_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  beat_q, beat_d;
  logic        handshake;

  assign handshake = AXIS_TVALID && AXIS_TREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rows_total_q <= '0;
      rows_sent_q  <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      rows_total_q <= rows_total_d;
      rows_sent_q  <= rows_sent_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      beat_q       <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rows_total_d = rows_total_q;
    rows_sent_d  = rows_sent_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    beat_d       = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_sent_d = '0;
          beat_d      = '0;
          if (row_count != 32'd0) begin
            rows_total_d = row_count;
            gap_d        = gap_cycles;
            state_d      = S_SEND;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            rows_sent_d = rows_sent_q + 32'd1;
            if (rows_sent_q + 32'd1 == rows_total_q) begin
              state_d = S_FINISH;
            end else if (gap_q != 16'd0) begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_GAP: begin
        // Down-counter loaded with the gap length; terminal count of 1 ends the gap.
        if (gap_cnt_q == 16'd1) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_SEND) || (state_q == S_GAP);
  assign done        = (state_q == S_FINISH);
  assign rows_sent   = rows_sent_q;
  assign AXIS_TVALID = (state_q == S_SEND);
  assign AXIS_TLAST  = AXIS_TVALID && (beat_q == LAST_BEAT);

  // rows_sent doubles as the row index while sending; payload is zero whenever TVALID is low.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign AXIS_TDATA[32*k +: 32] = AXIS_TVALID ? {rows_sent_q[15:0], beat_q, 8'(k)} : 32'd0;
  end

endmodule

// File: tb/tb_axis_row_generator.sv
// Scoreboarded bench for axis_row_generator: a reference model queues every expected beat per run,
// a negedge monitor pops and compares on each handshake and checks stability across stalls.
module tb_axis_row_generator;

  localparam int DW    = 512;
  localparam int BPR   = 66;
  localparam int LANES = DW / 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [31:0]   row_count;
  logic [15:0]   gap_cycles;
  logic          busy;
  logic          done;
  logic [31:0]   rows_sent;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b1;

  axis_row_generator #(.DATA_WIDTH(DW), .BEATS_PER_ROW(BPR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .row_count  (row_count),
    .gap_cycles (gap_cycles),
    .busy       (busy),
    .done       (done),
    .rows_sent  (rows_sent),
    .AXIS_TDATA (tdata),
    .AXIS_TVALID(tvalid),
    .AXIS_TLAST (tlast),
    .AXIS_TREADY(tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  beat_t         exp_b;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  bit            rdy_rand = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            low_cnt = 0;
  int            tlast_cnt = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int r, input int b);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) d[32*k +: 32] = {r[15:0], b[7:0], k[7:0]};
    return d;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_data);
        chk("stall_last", tlast, prev_last);
      end
      if (busy && !tvalid) low_cnt++;
      if (done) done_cnt++;
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got lane0 %0h while no beat was expected", tdata[31:0]);
        end else begin
          exp_b = sb.pop_front();
          chk("beat_data", tdata, exp_b.data);
          chk("beat_last", tlast, exp_b.last);
        end
        if (tlast) tlast_cnt++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // poke_mid: loop index at which an extra start (row_count=9) is pulsed mid-run; -1 for none.
  // poke_done: pulse start in the done cycle, which must be ignored.
  task automatic run(input int rc, input int gap, input bit rnd, input int poke_mid, input bit poke_done);
    int lat;
    int d0;
    bit seen;
    for (int r = 0; r < rc; r++)
      for (int b = 0; b < BPR; b++) sb.push_back('{pattern(r, b), (b == BPR - 1)});
    rdy_rand = rnd;
    @(posedge clk);
    #1;
    low_cnt    = 0;
    tlast_cnt  = 0;
    d0         = done_cnt;
    start      = 1'b1;
    row_count  = rc;
    gap_cycles = 16'(gap);
    @(posedge clk);
    #1;
    start      = 1'b0;
    row_count  = $urandom;
    gap_cycles = 16'($urandom);
    @(negedge clk);
    lat = 1;
    chk("busy_cycle1", busy, rc != 0);
    chk("valid_cycle1", tvalid, rc != 0);
    seen = done;
    while (!seen && lat < 20000) begin
      if (lat == poke_mid) begin
        start     = 1'b1;
        row_count = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      seen = done;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (!rnd && seen) chk("done_latency", lat, (rc == 0) ? 1 : rc * BPR + (rc - 1) * gap + 1);
    chk("rows_sent_final", rows_sent, rc);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", tvalid, 0);
    chk("tlast_count", tlast_cnt, rc);
    chk("gap_low_cycles", low_cnt, (rc == 0) ? 0 : (rc - 1) * gap);
    chk("beats_outstanding", sb.size(), 0);
    if (poke_done) begin
      start      = 1'b1;
      row_count  = 32'd5;
      gap_cycles = 16'd0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("rows_sent_hold", rows_sent, rc);
    if (poke_done) begin
      repeat (3) @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
    end
    chk("done_pulse_count", done_cnt - d0, 1);
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    row_count  = '0;
    gap_cycles = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rows_sent", rows_sent, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    run(1, 0, 0, -1, 0);
    run(3, 0, 0, -1, 0);
    run(2, 5, 1, -1, 0);
    run(0, 0, 0, -1, 0);
    run(4, 0, 0, 100, 0);
    run(1, 0, 0, -1, 1);

    // Reset during beat 30 of row 1.
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < BPR; b++) sb.push_back('{pattern(r, b), (b == BPR - 1)});
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    start      = 1'b1;
    row_count  = 32'd2;
    gap_cycles = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (96) @(posedge clk);
    #2;
    chk("pre_reset_beat", tdata, pattern(1, 30));
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_rows_sent", rows_sent, 0);
    chk("async_rst_tdata", tdata, 0);
    chk("async_rst_tvalid", tvalid, 0);
    chk("async_rst_tlast", tlast, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_tvalid", tvalid, 0);
    mon_en = 1'b1;
    run(1, 0, 0, -1, 0);

    run(10, 0, 0, -1, 0);
    for (int i = 0; i < 4; i++) run($urandom_range(1, 3), $urandom_range(0, 6), 1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_row_generator.md
# axis_row_generator

Upstream source for the row consumer stage: emits a commanded number of fixed-length rows on an AXI-Stream master interface, 66 beats per row by default, with a deterministic, checkable data pattern. An optional idle gap separates rows, and downstream back-pressure via AXIS_TREADY is honoured. The block reports progress (busy, rows_sent) and strobes done when the final row has been accepted. It is used to drive the row-counting consumer in bring-up and throughput tests.

## Interface
- DATA_WIDTH, 512, stream width in bits; must be a multiple of 32, at most 8192.
- BEATS_PER_ROW, 66, beats per row; range 1..256.
- clk  input  1  system clock; all logic is on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; ignored while busy=1.
- row_count  input  32  number of rows to send; sampled on the start cycle.
- gap_cycles  input  16  idle cycles inserted between rows; sampled on the start cycle.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle strobe at completion.
- rows_sent  output  32  rows fully accepted since the last accepted start.
- AXIS_TDATA  output  DATA_WIDTH  beat payload.
- AXIS_TVALID  output  1  beat valid.
- AXIS_TLAST  output  1  high on the final beat of each row.
- AXIS_TREADY  input  1  downstream ready.

## Operation
- Reset value of every output is 0: busy, done, rows_sent, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST.
- The states are IDLE, SEND, GAP and FINISH. Transitions:
  - IDLE→SEND: start=1 and row_count≠0. row_count and gap_cycles are latched; rows_sent, row index and beat index are cleared.
  - IDLE→FINISH: start=1 and row_count=0. No beats are emitted.
  - SEND: AXIS_TVALID=1. The beat index advances on each handshake (TVALID&TREADY).
    - On the last-beat handshake, rows_sent and the row index increment.
    - If that row was the final row, go to FINISH.
    - Otherwise, if gap_cycles=0, stay in SEND and start beat 0 of the next row on the following cycle, with TVALID held high.
    - Otherwise go to GAP.
  - GAP: TVALID=0 for exactly gap_cycles cycles, then SEND.
  - FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Data pattern for lane k (bits 32k+31:32k) of beat b in row r is {r[15:0], b[7:0], k[7:0]}.
  - r, b and k are all zero-based.
  - r wraps modulo 2^16 in the pattern only; rows_sent does not wrap below 2^32.
- AXIS_TLAST is high only on beat BEATS_PER_ROW-1.
- AXI-Stream rule: once TVALID is asserted, TVALID, TDATA and TLAST hold stable until the handshake. TVALID never drops mid-row without a handshake.
- TREADY may toggle arbitrarily. Stalls only extend the row; they never skip or repeat a beat.
- A start pulse while busy is ignored completely; latched parameters and counters are unaffected.
- rows_sent holds its final value after done until the next accepted start.
- Reset asserted mid-operation forces every output to 0 immediately (asynchronously) and returns the block to IDLE. No partial row is resumed after reset.

## Timing
- start sampled at cycle 0 → busy=1 and TVALID=1 with row 0, beat 0 at cycle 1.
- With TREADY held at 1, one beat transfers per cycle, so a row takes BEATS_PER_ROW cycles.
- Last beat of a non-final row accepted at cycle N, gap G>0 → TVALID=0 for cycles N+1..N+G; the next row's beat 0 is valid at cycle N+1+G.
- Last beat of the final row accepted at cycle N → at N+1: TVALID=0, done=1, busy=0, rows_sent=row_count.
- row_count=0 → done=1 at cycle 1, busy never asserts, TVALID never asserts.
- A start arriving in the same cycle that done is high is ignored, because the block is still in FINISH. A start in the cycle after done is accepted.
- rows_sent updates in the cycle after the last-beat handshake.

## Test plan
- Single row: row_count=1, gap=0, TREADY=1.
  - Expect exactly 66 beats on cycles 1..66, with TLAST only on beat 65.
  - Lane 3 of beat 10 = 0x00000A03.
  - done=1 at cycle 67; rows_sent=1.
- Back-to-back rows: row_count=3, gap=0, TREADY=1.
  - Expect 198 contiguous beats with TVALID never low.
  - Beat 0 of row 2 has lane 0 = 0x00020000.
  - done at cycle 199.
- Gap and back-pressure: row_count=2, gap=5, TREADY randomly 50% duty.
  - TDATA, TVALID and TLAST stay stable across every stall.
  - Exactly 5 TVALID-low cycles occur between rows.
  - 132 beats total, in pattern order.
- Zero rows and ignored start: row_count=0 → done at cycle 1 with no TVALID.
  - Then, during a 4-row run, pulse start with row_count=9 mid-run.
  - Expect rows_sent to end at 4, with a single done pulse.
- Reset mid-row: assert resetn=0 at beat 30 of row 1.
  - All outputs are 0 asynchronously.
  - After release the block is idle; a new start with row_count=1 produces beat 0 of row 0.
- Consumer pairing: connect to the row consumer with row_count=10, gap=0.
  - Expect exactly 10 row_complete strobes, each coincident with an accepted TLAST beat.
